// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, START, WAIT)
//   UART_DATA_W : default byte width used by the arbiter
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Purely combinational round-robin picker. The search starts one index
// above the previously granted requester and wraps around, so the requester
// that was served last has the lowest priority.
// Parameters:
//   NREQ  : number of requesters
//   IDX_W : width of an index into the request vector
// Ports:
//   req    : in  [NREQ-1:0]  active request levels
//   last   : in  [IDX_W-1:0] previously granted index
//   winner : out [IDX_W-1:0] selected index (0 when valid is low)
//   valid  : out             at least one request is active
// ---------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Walk the NREQ candidates in priority order starting at last+1; the
  // first active one wins. The wrap is done by subtraction because the sum
  // never reaches 2*NREQ.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!valid && req[idx[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between NREQ requesters. A request is granted
// round-robin, its byte is latched onto tx_data, a one-cycle active-low
// start strobe is issued, and the arbiter then waits for the transmitter's
// completion pulse before reporting 'sent' and returning to idle.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN): a watchdog counts cycles in
// WAIT; after TIMEOUT_CYC cycles without tx_done the transfer is abandoned,
// no 'sent' is given and the sticky err flag is raised until reset. Without
// the macro there is no counter and err is constant 0.
//
// Parameters:
//   NREQ        : number of requesters (2..8)
//   DATA_W      : byte width per requester
//   TIMEOUT_CYC : watchdog limit in clock cycles (timeout build only)
// Ports:
//   Clk      : in                 single rising-edge clock
//   Rst      : in                 synchronous active-high reset
//   req      : in  [NREQ-1:0]     level requests, held until ack
//   req_data : in  [NREQ*DATA_W]  flat bytes, requester i at [i*DATA_W +: DATA_W]
//   ack      : out [NREQ-1:0]     one-cycle pulse when a byte is latched
//   sent     : out [NREQ-1:0]     one-cycle pulse when a byte has gone out
//   tx_data  : out [DATA_W-1:0]   byte presented to the transmitter
//   start_tx : out                active-low start strobe, idles high
//   tx_done  : in                 transmitter completion pulse
//   err      : out                sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  output logic [NREQ-1:0]        sent,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   start_tx,
  input  logic                   tx_done,
  output logic                   err
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [DATA_W-1:0] tx_data_d;
  logic [NREQ-1:0]   ack_d, sent_d;
  logic              start_tx_d;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              timeout_hit;

  uart_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             err_q;

  // Watchdog counter: counts completed WAIT cycles and is cleared whenever
  // the FSM is anywhere else, so every transfer starts from zero.
  always_ff @(posedge Clk) begin
    if (Rst || state_q != WAIT) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  // The last permitted WAIT cycle is the one where the count is one short of
  // the limit; a tx_done in that same cycle still wins over the timeout.
  assign timeout_hit = (state_q == WAIT) && !tx_done &&
                       (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Sticky error flag, only cleared by reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state and next-output logic. Outputs are computed here and
  // registered below so ack, sent and start_tx come straight from flops.
  // start_tx_d goes low on the grant edge so the strobe covers exactly the
  // START cycle. tx_data only changes on a grant, which keeps it stable for
  // the whole transfer whatever the requesters do meanwhile.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_d      = cur_q;
    tx_data_d  = tx_data;
    ack_d      = '0;
    sent_d     = '0;
    start_tx_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          cur_d          = pick_idx;
          tx_data_d      = req_data[pick_idx*DATA_W +: DATA_W];
          ack_d[pick_idx] = 1'b1;
          start_tx_d     = 1'b0;
          state_d        = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          sent_d[cur_q] = 1'b1;
          last_d        = cur_q;
          state_d       = IDLE;
        end else if (timeout_hit) begin
          last_d  = cur_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset parks 'last' on the top index so the
  // first grant afterwards goes to the lowest active requester.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NREQ - 1);
      cur_q    <= '0;
      tx_data  <= '0;
      ack      <= '0;
      sent     <= '0;
      start_tx <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      tx_data  <= tx_data_d;
      ack      <= ack_d;
      sent     <= sent_d;
      start_tx <= start_tx_d;
    end
  end

endmodule
